cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have port clk  input  1  system clock, rising-edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port rdy  input  1  global ready; low = full stall.
REQ-004 SHALL have port rollback  input  1  mispredict flush.
REQ-005 SHALL have port alu_valid  input  1  ALU result offered.
REQ-006 SHALL have port alu_rob_pos  input  4  ROB position of ALU result.
REQ-007 SHALL have port alu_val  input  32  ALU result value.
REQ-008 SHALL have port alu_ready  output  1  ALU queue can accept this cycle.
REQ-009 SHALL have port lsb_valid  input  1  LSB result offered.
REQ-010 SHALL have port lsb_rob_pos  input  4  ROB position of LSB result.
REQ-011 SHALL have port lsb_val  input  32  LSB load value.
REQ-012 SHALL have port lsb_ready  output  1  LSB queue can accept this cycle.
REQ-013 SHALL have port cdb_valid  output  1  broadcast valid, registered.
REQ-014 SHALL have port cdb_rob_pos  output  4  broadcast ROB position, registered.
REQ-015 SHALL have port cdb_val  output  32  broadcast value, registered.
REQ-016 SHALL have port cdb_src  output  1  0 = ALU, 1 = LSB, registered.

Function
REQ-017 SHALL hold one 2-entry FIFO per source (ALU, LSB), each entry {rob_pos, val}.
REQ-018 SHALL drive x_ready = rdy && !rollback && (count_x < 2), independent of same-cycle pops.
REQ-019 SHALL push an entry on a rising edge where x_valid && x_ready; x_valid while x_ready is low is ignored, and the source must hold its data.
REQ-020 SHALL select one source per rdy cycle from the FIFO heads present at the start of the cycle: one non-empty FIFO wins; if both are non-empty, the source not named by last_grant wins.
REQ-021 SHALL, on a grant, pop the winning head, load it into the cdb_* registers with cdb_valid=1 and cdb_src=winner, and set last_grant=winner.
REQ-022 SHALL load cdb_valid=0 on a rdy cycle with no grant; cdb_rob_pos, cdb_val and cdb_src hold.
REQ-023 SHALL give a latency of 2 cycles: a push in cycle N into an empty, uncontested FIFO appears on cdb_* in cycle N+2.
REQ-024 SHALL support a simultaneous push and pop on the same FIFO; the count is unchanged.
REQ-025 SHALL wrap the FIFO read/write pointers modulo 2.
REQ-026 SHALL, when rdy=0, hold all state (FIFOs, pointers, counts, last_grant, cdb_*); consumers qualify cdb_valid with rdy.
REQ-027 SHALL, on rollback (with rdy=1), empty both FIFOs, clear cdb_valid, drop any same-cycle input, and leave last_grant unchanged.
REQ-028 SHALL give rst priority over rollback, and rollback priority over rdy=0.
REQ-029 SHALL never broadcast an entry twice and SHALL never lose an accepted entry except through rollback or rst.
REQ-030 SHALL, under continuous contention, alternate grants ALU/LSB, so no source waits more than one grant.

Reset
REQ-031 SHALL, on rst, set FIFO counts and pointers to 0, cdb_valid=0, cdb_rob_pos=0, cdb_val=0, cdb_src=0, and last_grant=1 (LSB), so ALU wins the first tie.
REQ-032 SHALL drive alu_ready=0 and lsb_ready=0 while rst is high.
REQ-033 SHALL, when rst is asserted mid-operation, discard all queued and in-flight entries; the first broadcast after rst is released is a push made after release.

Structure
REQ-034 SHALL take ROB_POS_WID, the 32-bit data width and CDB_FIFO_DEPTH=2 from the shared Mydefine.v definitions.
REQ-035 SHALL implement each queue as a sub-module cdb_fifo (depth 2, ports push/pop/flush/full/empty/head), instantiated twice.
REQ-036 SHALL be a single always block for the arbiter and output registers, with no combinational path from x_valid to cdb_*.

Verification
REQ-037 SHALL cover this case: after rst, ALU push {pos 3, 0x11} in cycle 1 -> cycle 3 shows cdb_valid=1, cdb_rob_pos=3, cdb_val=0x11, cdb_src=0.
REQ-038 SHALL cover this case: ALU {1,0xA} and LSB {2,0xB} pushed in the same cycle after rst -> ALU broadcast first, LSB on the next cycle.
REQ-039 SHALL cover this case: three back-to-back LSB pushes while the ALU queue has 2 entries -> lsb_ready drops at count 2, grant order ALU, LSB, ALU, LSB, LSB, and no entry is lost.
REQ-040 SHALL cover this case: rollback asserted with both queues full and cdb_valid=1 -> next cycle cdb_valid=0, both readys=1, and no stale broadcast follows.
REQ-041 SHALL cover this case: rdy held low 3 cycles with a pending broadcast -> cdb_* and counts unchanged, and the broadcast sequence resumes identically afterwards.
REQ-042 SHALL cover this case: rst asserted the cycle after a push -> cdb_valid stays 0 and no broadcast of that entry ever appears.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, FIFO entry layout and source encoding for the common data bus arbiter.
package cdb_arbiter_pkg;

  localparam int ROB_POS_WID    = 4;
  localparam int DATA_WID       = 32;
  localparam int CDB_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [ROB_POS_WID-1:0] rob_pos;
    logic [DATA_WID-1:0]    val;
  } cdb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } cdb_src_e;

endpackage

// File: rtl/cdb_fifo.sv
// Two-entry result queue feeding the CDB arbiter; one instance per producing unit.
module cdb_fifo
  import cdb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  cdb_entry_t din,
  output logic       full,
  output logic       empty,
  output cdb_entry_t head
);

  cdb_entry_t mem [CDB_FIFO_DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 2'(CDB_FIFO_DEPTH));
  assign empty   = (count == 2'd0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // NOTE: storage is deliberately not reset; count gates every read, so stale slots are never seen.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: non-blocking assignments so count and both pointers all update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      // One-bit pointers wrap modulo the depth by themselves.
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Arbitrates ALU and LSB results onto one registered CDB broadcast, alternating under contention.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rollback,
  input  logic                   alu_valid,
  input  logic [ROB_POS_WID-1:0] alu_rob_pos,
  input  logic [DATA_WID-1:0]    alu_val,
  output logic                   alu_ready,
  input  logic                   lsb_valid,
  input  logic [ROB_POS_WID-1:0] lsb_rob_pos,
  input  logic [DATA_WID-1:0]    lsb_val,
  output logic                   lsb_ready,
  output logic                   cdb_valid,
  output logic [ROB_POS_WID-1:0] cdb_rob_pos,
  output logic [DATA_WID-1:0]    cdb_val,
  output logic                   cdb_src
);

  cdb_entry_t alu_din, lsb_din, alu_head, lsb_head, win_head;
  logic       alu_full, alu_empty, lsb_full, lsb_empty;
  logic       active, grant, alu_pop, lsb_pop;
  cdb_src_e   winner, last_grant;

  assign active    = rdy && !rollback && !rst;
  assign alu_ready = active && !alu_full;
  assign lsb_ready = active && !lsb_full;
  assign alu_din   = {alu_rob_pos, alu_val};
  assign lsb_din   = {lsb_rob_pos, lsb_val};

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    grant    = 1'b0;
    winner   = SRC_ALU;
    win_head = alu_head;
    if (active) begin
      if (!alu_empty && !lsb_empty) begin
        grant  = 1'b1;
        winner = (last_grant == SRC_LSB) ? SRC_ALU : SRC_LSB;
      end else if (!alu_empty) begin
        grant  = 1'b1;
        winner = SRC_ALU;
      end else if (!lsb_empty) begin
        grant  = 1'b1;
        winner = SRC_LSB;
      end
    end
    if (winner == SRC_LSB) win_head = lsb_head;
  end

  assign alu_pop = grant && (winner == SRC_ALU);
  assign lsb_pop = grant && (winner == SRC_LSB);

  cdb_fifo u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (alu_valid && alu_ready),
    .pop   (alu_pop),
    .flush (rollback),
    .din   (alu_din),
    .full  (alu_full),
    .empty (alu_empty),
    .head  (alu_head)
  );

  cdb_fifo u_lsb_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (lsb_valid && lsb_ready),
    .pop   (lsb_pop),
    .flush (rollback),
    .din   (lsb_din),
    .full  (lsb_full),
    .empty (lsb_empty),
    .head  (lsb_head)
  );

  // Rollback outranks a stall; a stall freezes the broadcast so consumers can qualify with rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid   <= 1'b0;
      cdb_rob_pos <= '0;
      cdb_val     <= '0;
      cdb_src     <= 1'b0;
      last_grant  <= SRC_LSB;
    end else if (rollback) begin
      cdb_valid <= 1'b0;
    end else if (rdy) begin
      cdb_valid <= grant;
      if (grant) begin
        cdb_rob_pos <= win_head.rob_pos;
        cdb_val     <= win_head.val;
        cdb_src     <= (winner == SRC_LSB);
        last_grant  <= winner;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench: a queue-level reference model compared every cycle, plus literal spot checks.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        alu_valid, lsb_valid;
  logic [3:0]  alu_rob_pos, lsb_rob_pos;
  logic [31:0] alu_val, lsb_val;
  logic        alu_ready, lsb_ready;
  logic        cdb_valid, cdb_src;
  logic [3:0]  cdb_rob_pos;
  logic [31:0] cdb_val;

  cdb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .rollback    (rollback),
    .alu_valid   (alu_valid),
    .alu_rob_pos (alu_rob_pos),
    .alu_val     (alu_val),
    .alu_ready   (alu_ready),
    .lsb_valid   (lsb_valid),
    .lsb_rob_pos (lsb_rob_pos),
    .lsb_val     (lsb_val),
    .lsb_ready   (lsb_ready),
    .cdb_valid   (cdb_valid),
    .cdb_rob_pos (cdb_rob_pos),
    .cdb_val     (cdb_val),
    .cdb_src     (cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pos;
    logic [31:0] val;
  } tb_entry_t;

  tb_entry_t   mq_alu[$];
  tb_entry_t   mq_lsb[$];
  logic        m_last;
  logic        m_valid;
  logic [3:0]  m_pos;
  logic [31:0] m_val;
  logic        m_src;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic exp_ready(input int depth_used);
    return !rst && rdy && !rollback && (depth_used < 2);
  endfunction

  // Advances the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    tb_entry_t e;
    logic      a_acc, l_acc, have_win, win;
    if (rst) begin
      mq_alu.delete();
      mq_lsb.delete();
      m_valid = 1'b0; m_pos = '0; m_val = '0; m_src = 1'b0; m_last = 1'b1;
    end else if (rollback) begin
      mq_alu.delete();
      mq_lsb.delete();
      m_valid = 1'b0;
    end else if (rdy) begin
      a_acc    = alu_valid && (mq_alu.size() < 2);
      l_acc    = lsb_valid && (mq_lsb.size() < 2);
      have_win = (mq_alu.size() > 0) || (mq_lsb.size() > 0);
      if (mq_alu.size() > 0 && mq_lsb.size() > 0) win = ~m_last;
      else win = (mq_lsb.size() > 0);
      if (have_win) begin
        e       = win ? mq_lsb.pop_front() : mq_alu.pop_front();
        m_valid = 1'b1; m_pos = e.pos; m_val = e.val; m_src = win; m_last = win;
      end else begin
        m_valid = 1'b0;
      end
      if (a_acc) begin e.pos = alu_rob_pos; e.val = alu_val; mq_alu.push_back(e); end
      if (l_acc) begin e.pos = lsb_rob_pos; e.val = lsb_val; mq_lsb.push_back(e); end
    end
  endtask

  task automatic compare_model();
    check("cdb_valid",   cdb_valid,   m_valid);
    check("cdb_rob_pos", cdb_rob_pos, m_pos);
    check("cdb_val",     cdb_val,     m_val);
    check("cdb_src",     cdb_src,     m_src);
    check("alu_ready",   alu_ready,   exp_ready(mq_alu.size()));
    check("lsb_ready",   lsb_ready,   exp_ready(mq_lsb.size()));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic expect_cdb(input logic v, input logic [3:0] p, input logic [31:0] d, input logic s);
    check("lit_valid", cdb_valid, v);
    if (v) begin
      check("lit_pos", cdb_rob_pos, p);
      check("lit_val", cdb_val, d);
      check("lit_src", cdb_src, s);
    end
  endtask

  task automatic drive_alu(input logic v, input logic [3:0] p, input logic [31:0] d);
    alu_valid = v; alu_rob_pos = p; alu_val = d;
  endtask

  task automatic drive_lsb(input logic v, input logic [3:0] p, input logic [31:0] d);
    lsb_valid = v; lsb_rob_pos = p; lsb_val = d;
  endtask

  initial begin
    logic a_pend, l_pend, a_acc, l_acc;
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    drive_alu(1'b0, 4'd0, 32'd0);
    drive_lsb(1'b0, 4'd0, 32'd0);

    // Reset state
    tick(); tick();
    expect_cdb(1'b0, 4'd0, 32'd0, 1'b0);
    check("rst_pos", cdb_rob_pos, 4'd0);
    check("rst_val", cdb_val, 32'd0);
    check("rst_src", cdb_src, 1'b0);
    check("rst_alu_ready", alu_ready, 1'b0);
    check("rst_lsb_ready", lsb_ready, 1'b0);
    rst = 1'b0;
    tick();
    check("idle_alu_ready", alu_ready, 1'b1);

    // Single ALU push shows up two cycles later
    drive_alu(1'b1, 4'd3, 32'h11);
    tick();
    drive_alu(1'b0, 4'd0, 32'd0);
    expect_cdb(1'b0, 4'd0, 32'd0, 1'b0);
    tick(); expect_cdb(1'b1, 4'd3, 32'h11, 1'b0);
    tick(); expect_cdb(1'b0, 4'd0, 32'd0, 1'b0);

    // Simultaneous push after reset: ALU wins the first tie
    rst = 1'b1; tick(); rst = 1'b0;
    drive_alu(1'b1, 4'd1, 32'hA);
    drive_lsb(1'b1, 4'd2, 32'hB);
    tick();
    drive_alu(1'b0, 4'd0, 32'd0);
    drive_lsb(1'b0, 4'd0, 32'd0);
    tick(); expect_cdb(1'b1, 4'd1, 32'hA, 1'b0);
    tick(); expect_cdb(1'b1, 4'd2, 32'hB, 1'b1);
    tick(); expect_cdb(1'b0, 4'd0, 32'd0, 1'b0);

    // Back-to-back LSB pushes against a busy ALU queue
    drive_alu(1'b1, 4'd4, 32'h100);
    drive_lsb(1'b1, 4'd6, 32'h200);
    tick();
    drive_alu(1'b1, 4'd5, 32'h101);
    drive_lsb(1'b1, 4'd7, 32'h201);
    tick(); expect_cdb(1'b1, 4'd4, 32'h100, 1'b0);
    check("lsb_ready_full", lsb_ready, 1'b0);
    drive_alu(1'b0, 4'd0, 32'd0);
    drive_lsb(1'b1, 4'd8, 32'h202);
    tick(); expect_cdb(1'b1, 4'd6, 32'h200, 1'b1);
    check("lsb_ready_again", lsb_ready, 1'b1);
    tick(); expect_cdb(1'b1, 4'd5, 32'h101, 1'b0);
    drive_lsb(1'b0, 4'd0, 32'd0);
    tick(); expect_cdb(1'b1, 4'd7, 32'h201, 1'b1);
    tick(); expect_cdb(1'b1, 4'd8, 32'h202, 1'b1);
    tick(); expect_cdb(1'b0, 4'd0, 32'd0, 1'b0);

    // Rollback with loaded queues and a live broadcast
    drive_alu(1'b1, 4'd0, 32'h300);
    drive_lsb(1'b1, 4'd8, 32'h400);
    tick();
    drive_alu(1'b1, 4'd1, 32'h301);
    drive_lsb(1'b1, 4'd9, 32'h401);
    tick(); expect_cdb(1'b1, 4'd0, 32'h300, 1'b0);
    drive_alu(1'b1, 4'd2, 32'h302);
    rollback = 1'b1;
    tick(); expect_cdb(1'b0, 4'd0, 32'd0, 1'b0);
    rollback = 1'b0;
    drive_alu(1'b0, 4'd0, 32'd0);
    drive_lsb(1'b0, 4'd0, 32'd0);
    #1;
    check("rb_alu_ready", alu_ready, 1'b1);
    check("rb_lsb_ready", lsb_ready, 1'b1);
    repeat (3) begin tick(); expect_cdb(1'b0, 4'd0, 32'd0, 1'b0); end

    // Rollback still flushes while stalled
    drive_alu(1'b1, 4'd14, 32'hE00);
    tick();
    drive_alu(1'b0, 4'd0, 32'd0);
    rdy = 1'b0; rollback = 1'b1;
    tick(); expect_cdb(1'b0, 4'd0, 32'd0, 1'b0);
    rdy = 1'b1; rollback = 1'b0;
    tick(); expect_cdb(1'b0, 4'd0, 32'd0, 1'b0);
    tick(); expect_cdb(1'b0, 4'd0, 32'd0, 1'b0);

    // Three-cycle stall with a broadcast pending and a held ALU offer
    rst = 1'b1; tick(); rst = 1'b0;
    drive_alu(1'b1, 4'd9, 32'h900);
    drive_lsb(1'b1, 4'd10, 32'hA00);
    tick();
    drive_lsb(1'b0, 4'd0, 32'd0);
    drive_alu(1'b1, 4'd11, 32'hB00);
    rdy = 1'b0;
    #1;
    check("stall_alu_ready", alu_ready, 1'b0);
    rdy = 1'b1;
    drive_alu(1'b0, 4'd0, 32'd0);
    tick(); expect_cdb(1'b1, 4'd9, 32'h900, 1'b0);
    rdy = 1'b0;
    drive_alu(1'b1, 4'd11, 32'hB00);
    repeat (3) begin tick(); expect_cdb(1'b1, 4'd9, 32'h900, 1'b0); end
    rdy = 1'b1;
    tick(); expect_cdb(1'b1, 4'd10, 32'hA00, 1'b1);
    drive_alu(1'b0, 4'd0, 32'd0);
    tick(); expect_cdb(1'b1, 4'd11, 32'hB00, 1'b0);
    tick(); expect_cdb(1'b0, 4'd0, 32'd0, 1'b0);

    // Reset right after a push discards that entry
    drive_alu(1'b1, 4'd12, 32'hC00);
    tick();
    drive_alu(1'b0, 4'd0, 32'd0);
    rst = 1'b1;
    tick(); expect_cdb(1'b0, 4'd0, 32'd0, 1'b0);
    rst = 1'b0;
    repeat (3) begin tick(); expect_cdb(1'b0, 4'd0, 32'd0, 1'b0); end
    drive_alu(1'b1, 4'd13, 32'hD00);
    tick();
    drive_alu(1'b0, 4'd0, 32'd0);
    tick(); expect_cdb(1'b1, 4'd13, 32'hD00, 1'b0);

    // Mixed pattern: stalls, rollbacks and held offers, checked against the model only
    a_pend = 1'b0; l_pend = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (!a_pend && (i % 3 != 0)) begin
        drive_alu(1'b1, 4'(i), 32'h1000 + i); a_pend = 1'b1;
      end
      if (!l_pend && (i % 2 == 0)) begin
        drive_lsb(1'b1, 4'(i + 5), 32'h2000 + i); l_pend = 1'b1;
      end
      rdy      = (i % 7 != 3);
      rollback = (i % 29 == 17);
      a_acc    = alu_valid && exp_ready(mq_alu.size());
      l_acc    = lsb_valid && exp_ready(mq_lsb.size());
      tick();
      if (a_acc) begin drive_alu(1'b0, 4'd0, 32'd0); a_pend = 1'b0; end
      if (l_acc) begin drive_lsb(1'b0, 4'd0, 32'd0); l_pend = 1'b0; end
    end
    drive_alu(1'b0, 4'd0, 32'd0);
    drive_lsb(1'b0, 4'd0, 32'd0);
    rdy = 1'b1; rollback = 1'b0;
    repeat (6) tick();
    check("drain_valid", cdb_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
